fir_seq_ctrl: RTL and testbench
===============================

// Module: fir_seq_ctrl
// PURPOSE
//  Sequencer/configurator in front of the 8-tap FIR datapath. Owns the shared 6-bit input bus:
//  routes words either into the coefficient shadow (config load) or into the FIR sample stream.
//  Commits coefficients atomically, gates sample valid, and flushes the delay line with zeros
//  after each burst so the tail of every burst is complete.
// PARAMETERS
//  NBR_OF_TAPS   8        number of FIR taps
//  TAP_SIZE      2        bits per tap coefficient (signed)
//  DATA_W        6        sample/word width
//  COEF_RESET    16'h4444 coefficients after reset (taps 01,00,01,00,... ; tap0 in MSBs)
// PORTS
//  clk          in   1                 clock, all logic on posedge
//  reset        in   1                 synchronous, active-low reset
//  in_data      in   DATA_W            shared word bus (sample or coefficient word)
//  in_valid     in   1                 in_data valid
//  in_ready     out  1                 word accepted when in_valid & in_ready
//  cfg_req      in   1                 level: 1 = words on bus are coefficient words
//  coeffs       out  NBR_OF_TAPS*TAP_SIZE  committed coefficients, tap0 = [MSB -: TAP_SIZE]
//  coeff_upd    out  1                 1-cycle pulse on coefficient commit
//  load_err     out  1                 1-cycle pulse on aborted load
//  fir_x_n      out  DATA_W            sample to FIR
//  fir_tvalid   out  1                 fir_x_n valid this cycle
//  busy         out  1                 state != IDLE
//  sample_cnt   out  8                 samples accepted in current burst, saturates at 255
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; coeffs=COEF_RESET; all other outputs 0; counters 0.
//  States: IDLE, LOAD, STREAM, DRAIN.
//  NW = ceil(NBR_OF_TAPS*TAP_SIZE/DATA_W) = 3 words; word0 -> coeffs[15:10], word1 -> [9:4],
//   word2[5:2] -> [3:0], word2[1:0] ignored. Words collect in a shadow reg, never in coeffs.
//  IDLE: in_ready=0. cfg_req=1 -> LOAD (priority). else in_valid=1 -> STREAM, sample_cnt<=0.
//  LOAD: in_ready=1. Each accepted word stored, word counter++. On NW-th accept: coeffs<=shadow
//   and coeff_upd=1 in the next cycle, -> IDLE. cfg_req falls before NW words: -> IDLE,
//   load_err=1 next cycle, coeffs unchanged, word counter cleared.
//  STREAM: in_ready = !cfg_req. Accepted sample: fir_x_n<=in_data, fir_tvalid<=1 (latency 1),
//   sample_cnt++ (saturate 255). No accept (in_valid=0 or cfg_req=1): -> DRAIN, drain cnt<=0.
//  DRAIN: in_ready = !cfg_req. Emit fir_x_n=0, fir_tvalid=1 for NBR_OF_TAPS consecutive cycles.
//   in_valid=1 & !cfg_req during DRAIN: accept as sample, -> STREAM, drain cnt cleared,
//   sample_cnt continues. After NBR_OF_TAPS zeros: -> LOAD if cfg_req=1, else IDLE.
//  cfg_req never interrupts a drain; a pending cfg_req is served right after the drain.
//  fir_tvalid=0 and fir_x_n=0 in IDLE and LOAD. sample_cnt holds in IDLE until next burst.
//  Reset mid-load or mid-stream: shadow discarded, coeffs back to COEF_RESET, no pulses.
// TESTING
//  1 reset: reset=0 2 cycles -> coeffs=16'h4444, busy=0, fir_tvalid=0, in_ready=0.
//  2 load: cfg_req=1, words 6'h3F,6'h00,6'h2C -> after 3rd accept coeffs=16'hFC0B,
//    coeff_upd one cycle, state IDLE.
//  3 abort: cfg_req=1, 2 words, cfg_req=0 -> load_err one cycle, coeffs unchanged.
//  4 burst: samples 1,2,3 back-to-back then in_valid=0 -> fir_x_n 1,2,3 at +1 cycle,
//    then 8 zero cycles with fir_tvalid=1, sample_cnt=3, then IDLE.
//  5 resume: in_valid=1 at drain cycle 4 -> drain stops, sample accepted, sample_cnt=4.
//  6 cfg during stream: cfg_req=1 mid-burst -> in_ready=0, full 8-cycle drain, then LOAD.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// Sequencer in front of the 8-tap FIR: routes the shared word bus into a coefficient
// shadow or the sample stream, commits coefficients atomically and zero-flushes after bursts.
module fir_seq_ctrl #(
    parameter int NBR_OF_TAPS = 8,
    parameter int TAP_SIZE    = 2,
    parameter int DATA_W      = 6,
    parameter logic [NBR_OF_TAPS*TAP_SIZE-1:0] COEF_RESET = 16'h4444
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              cfg_req,
    output logic [NBR_OF_TAPS*TAP_SIZE-1:0]   coeffs,
    output logic                              coeff_upd,
    output logic                              load_err,
    output logic [DATA_W-1:0]                 fir_x_n,
    output logic                              fir_tvalid,
    output logic                              busy,
    output logic [7:0]                        sample_cnt
);

    // state  | meaning
    // IDLE   | bus not accepted, waiting for cfg_req or a sample
    // LOAD   | collecting coefficient words into the shadow
    // STREAM | forwarding samples to the FIR
    // DRAIN  | pushing NBR_OF_TAPS zeros through the delay line

    localparam int CW  = NBR_OF_TAPS * TAP_SIZE;
    localparam int NW  = (CW + DATA_W - 1) / DATA_W;
    localparam int SW  = NW * DATA_W;
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
    localparam int DCW = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    state_t             state_q;
    logic [SW-1:0]      shadow_q, shadow_d;
    logic [WCW-1:0]     word_cnt_q;
    logic [DCW-1:0]     drain_cnt_q;
    logic [CW-1:0]      coeffs_q;
    logic               coeff_upd_q, load_err_q, fir_tvalid_q;
    logic [DATA_W-1:0]  fir_x_n_q;
    logic [7:0]         sample_cnt_q, sample_cnt_inc;
    logic               accept, last_word;

    always_comb begin
        case (state_q)
            LOAD:          in_ready = 1'b1;
            STREAM, DRAIN: in_ready = !cfg_req;
            default:       in_ready = 1'b0;
        endcase
    end

    assign accept         = in_valid && in_ready;
    assign last_word      = (word_cnt_q == WCW'(NW - 1));
    assign sample_cnt_inc = (sample_cnt_q == 8'hFF) ? 8'hFF : sample_cnt_q + 8'd1;

    // word k lands MSB-first; trailing bits of the last word fall off the coeff slice
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NW; k++) begin
            if (word_cnt_q == WCW'(k))
                shadow_d[SW-1-k*DATA_W -: DATA_W] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            word_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            coeffs_q     <= COEF_RESET;
            coeff_upd_q  <= 1'b0;
            load_err_q   <= 1'b0;
            fir_tvalid_q <= 1'b0;
            fir_x_n_q    <= '0;
            sample_cnt_q <= '0;
        end else begin
            coeff_upd_q <= 1'b0;
            load_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    fir_tvalid_q <= 1'b0;
                    fir_x_n_q    <= '0;
                    if (cfg_req) begin
                        word_cnt_q <= '0;
                        state_q    <= LOAD;
                    end else if (in_valid) begin
                        sample_cnt_q <= '0;
                        state_q      <= STREAM;
                    end
                end
                LOAD: begin
                    fir_tvalid_q <= 1'b0;
                    fir_x_n_q    <= '0;
                    if (!cfg_req) begin
                        load_err_q <= 1'b1;
                        word_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else if (in_valid) begin
                        shadow_q <= shadow_d;
                        if (last_word) begin
                            coeffs_q    <= shadow_d[SW-1 -: CW];
                            coeff_upd_q <= 1'b1;
                            word_cnt_q  <= '0;
                            state_q     <= IDLE;
                        end else begin
                            word_cnt_q <= word_cnt_q + WCW'(1);
                        end
                    end
                end
                STREAM: begin
                    fir_tvalid_q <= 1'b1;
                    if (accept) begin
                        fir_x_n_q    <= in_data;
                        sample_cnt_q <= sample_cnt_inc;
                    end else begin
                        // first flush zero is registered here so it lines up with DRAIN cycle 1
                        fir_x_n_q   <= '0;
                        drain_cnt_q <= DCW'(NBR_OF_TAPS - 1);
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        fir_tvalid_q <= 1'b1;
                        fir_x_n_q    <= in_data;
                        sample_cnt_q <= sample_cnt_inc;
                        drain_cnt_q  <= '0;
                        state_q      <= STREAM;
                    end else if (drain_cnt_q == '0) begin
                        fir_tvalid_q <= 1'b0;
                        fir_x_n_q    <= '0;
                        word_cnt_q   <= '0;
                        state_q      <= cfg_req ? LOAD : IDLE;
                    end else begin
                        fir_tvalid_q <= 1'b1;
                        fir_x_n_q    <= '0;
                        drain_cnt_q  <= drain_cnt_q - DCW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coeffs     = coeffs_q;
    assign coeff_upd  = coeff_upd_q;
    assign load_err   = load_err_q;
    assign fir_x_n    = fir_x_n_q;
    assign fir_tvalid = fir_tvalid_q;
    assign busy       = (state_q != IDLE);
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: per-cycle vector table for load/abort, scoreboarded FIR stream
// for bursts, resume, cfg-during-stream, saturation and mid-load reset.
module tb_fir_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        cfg_req;
    logic [15:0] coeffs;
    logic        coeff_upd;
    logic        load_err;
    logic [5:0]  fir_x_n;
    logic        fir_tvalid;
    logic        busy;
    logic [7:0]  sample_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    fir_seq_ctrl dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cfg_req(cfg_req), .coeffs(coeffs), .coeff_upd(coeff_upd),
        .load_err(load_err), .fir_x_n(fir_x_n), .fir_tvalid(fir_tvalid), .busy(busy),
        .sample_cnt(sample_cnt)
    );

    typedef struct {
        logic       cfg;
        logic       val;
        logic [5:0] d;
        logic       rdy;
        logic       bsy;
        logic       upd;
        logic       err;
        logic [15:0] co;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic v, input logic [5:0] d,
                                input logic r, input logic b, input logic u,
                                input logic e, input logic [15:0] co);
        vec_t t;
        t.cfg = c; t.val = v; t.d = d; t.rdy = r; t.bsy = b; t.upd = u; t.err = e; t.co = co;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // hold a word on the bus until accepted; samples go to the scoreboard
    task automatic xfer(input logic [5:0] d, input bit smp);
        bit ok;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (in_ready) begin
                if (smp) exp_q.push_back(d);
                step();
                ok = 1'b1;
                if (smp) begin
                    chk("lat_tvalid", 32'(fir_tvalid), 32'd1);
                    chk("lat_x_n", 32'(fir_x_n), 32'(d));
                end
                break;
            end
            step();
        end
        chk("xfer_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) step();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic end_burst();
        in_valid = 1'b0;
        repeat (8) exp_q.push_back(6'd0);
        wait_idle();
        chk("drain_tvalid_off", 32'(fir_tvalid), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && fir_tvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL fir_extra_valid: got x_n=0x%0h with no output expected at %0t",
                         fir_x_n, $time);
            end else begin
                chk("fir_x_n_sb", 32'(fir_x_n), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[20];
        vt[0]  = mk(0, 0, 6'h00, 0, 0, 0, 0, 16'h4444);
        vt[1]  = mk(1, 0, 6'h00, 0, 0, 0, 0, 16'h4444);
        vt[2]  = mk(1, 1, 6'h3F, 1, 1, 0, 0, 16'h4444);
        vt[3]  = mk(1, 0, 6'h00, 1, 1, 0, 0, 16'h4444);
        vt[4]  = mk(1, 1, 6'h00, 1, 1, 0, 0, 16'h4444);
        vt[5]  = mk(1, 1, 6'h2C, 1, 1, 0, 0, 16'h4444);
        vt[6]  = mk(0, 0, 6'h00, 0, 0, 1, 0, 16'hFC0B);
        vt[7]  = mk(0, 0, 6'h00, 0, 0, 0, 0, 16'hFC0B);
        vt[8]  = mk(1, 0, 6'h00, 0, 0, 0, 0, 16'hFC0B);
        vt[9]  = mk(1, 1, 6'h15, 1, 1, 0, 0, 16'hFC0B);
        vt[10] = mk(1, 1, 6'h2A, 1, 1, 0, 0, 16'hFC0B);
        vt[11] = mk(0, 0, 6'h00, 1, 1, 0, 0, 16'hFC0B);
        vt[12] = mk(0, 0, 6'h00, 0, 0, 0, 1, 16'hFC0B);
        vt[13] = mk(0, 0, 6'h00, 0, 0, 0, 0, 16'hFC0B);
        vt[14] = mk(1, 0, 6'h00, 0, 0, 0, 0, 16'hFC0B);
        vt[15] = mk(1, 1, 6'h00, 1, 1, 0, 0, 16'hFC0B);
        vt[16] = mk(1, 1, 6'h3F, 1, 1, 0, 0, 16'hFC0B);
        vt[17] = mk(1, 1, 6'h3D, 1, 1, 0, 0, 16'hFC0B);
        vt[18] = mk(0, 0, 6'h00, 0, 0, 1, 0, 16'h03FF);
        vt[19] = mk(0, 0, 6'h00, 0, 0, 0, 0, 16'h03FF);

        reset = 1'b0; cfg_req = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_coeffs", 32'(coeffs), 32'h4444);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tvalid", 32'(fir_tvalid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_upd", 32'(coeff_upd), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_scnt", 32'(sample_cnt), 32'd0);
        reset = 1'b1;

        // load, stall, abort, and a clean reload after the abort
        for (int i = 0; i < 20; i++) begin
            cfg_req  = vt[i].cfg;
            in_valid = vt[i].val;
            in_data  = vt[i].d;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
            chk($sformatf("v%0d_upd", i), 32'(coeff_upd), 32'(vt[i].upd));
            chk($sformatf("v%0d_err", i), 32'(load_err), 32'(vt[i].err));
            chk($sformatf("v%0d_coeffs", i), 32'(coeffs), 32'(vt[i].co));
            step();
        end

        // plain burst
        xfer(6'd1, 1'b1);
        xfer(6'd2, 1'b1);
        xfer(6'd3, 1'b1);
        chk("burst_scnt", 32'(sample_cnt), 32'd3);
        end_burst();
        chk("burst_scnt_hold", 32'(sample_cnt), 32'd3);

        // resume in drain cycle 4
        xfer(6'd7, 1'b1);
        xfer(6'd8, 1'b1);
        xfer(6'd9, 1'b1);
        in_valid = 1'b0;
        repeat (4) exp_q.push_back(6'd0);
        repeat (4) step();
        chk("resume_in_drain", 32'(busy), 32'd1);
        xfer(6'd10, 1'b1);
        chk("resume_scnt", 32'(sample_cnt), 32'd4);
        end_burst();
        chk("resume_scnt_hold", 32'(sample_cnt), 32'd4);

        // cfg_req during stream: full drain first, then LOAD
        xfer(6'd11, 1'b1);
        xfer(6'd12, 1'b1);
        cfg_req = 1'b1;
        in_data = 6'd13;
        #1;
        chk("cfg_stream_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        repeat (8) exp_q.push_back(6'd0);
        begin
            int n;
            n = 0;
            for (int i = 1; i <= 30; i++) begin
                step();
                n = i;
                if (in_ready) break;
            end
            chk("cfg_drain_cycles", 32'(n), 32'd9);
        end
        chk("cfg_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("cfg_scnt", 32'(sample_cnt), 32'd2);
        xfer(6'h2A, 1'b0);
        xfer(6'h15, 1'b0);
        xfer(6'h00, 1'b0);
        chk("cfg_load_upd", 32'(coeff_upd), 32'd1);
        chk("cfg_load_coeffs", 32'(coeffs), 32'hA950);
        in_valid = 1'b0;
        cfg_req  = 1'b0;
        step();
        chk("cfg_load_upd_pulse", 32'(coeff_upd), 32'd0);

        // saturation of sample_cnt
        for (int i = 0; i < 260; i++) xfer(6'(i), 1'b1);
        chk("sat_scnt", 32'(sample_cnt), 32'd255);
        end_burst();

        // reset in the middle of a load
        cfg_req = 1'b1;
        xfer(6'h3F, 1'b0);
        xfer(6'h3F, 1'b0);
        reset = 1'b0; in_valid = 1'b0; cfg_req = 1'b0;
        step();
        chk("mrst_coeffs", 32'(coeffs), 32'h4444);
        chk("mrst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        step();
        chk("mrst_no_err", 32'(load_err), 32'd0);
        chk("mrst_no_upd", 32'(coeff_upd), 32'd0);
        cfg_req = 1'b1;
        xfer(6'h01, 1'b0);
        xfer(6'h02, 1'b0);
        chk("mrst_no_early_upd", 32'(coeff_upd), 32'd0);
        xfer(6'h03, 1'b0);
        chk("mrst_reload_upd", 32'(coeff_upd), 32'd1);
        chk("mrst_reload_coeffs", 32'(coeffs), 32'h0420);
        in_valid = 1'b0;
        cfg_req  = 1'b0;
        repeat (3) step();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
